// File: rtl/nco_period_detector.sv
// nco_period_detector
//
// Measures the period of a signed sine stream, counted in valid samples, and
// reports when that period has stayed stable for a number of measurements.
// A rising crossing needs the waveform to first fall to -HYST ("arm") and then
// rise to +HYST. The valid-sample distance between two crossings is the period.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   sample_valid  qualifies sample this cycle
//   sample        signed 16-bit sine sample
//   period        last measured period (valid samples); holds between updates
//   period_valid  one-cycle pulse, period was just updated
//   locked        LOCK_CNT consecutive periods within +/-TOL of their predecessor
//   timeout       one-cycle pulse, no crossing seen within MAX_PERIOD samples
module nco_period_detector #(
  parameter logic [15:0] HYST       = 16'd256,
  parameter logic [15:0] MAX_PERIOD = 16'd4096,
  parameter int          LOCK_CNT   = 4,
  parameter int          TOL        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        timeout
);

  localparam int DATA_W = 16;
  localparam int DIFF_W = DATA_W + 1;
  localparam int MC_W   = $clog2(LOCK_CNT + 1);

  // Thresholds and tolerance widened to 17 bits so that +/-HYST and any
  // period difference are representable without wrap.
  localparam logic signed [DIFF_W-1:0] HYST_POS = $signed({1'b0, HYST});
  localparam logic signed [DIFF_W-1:0] HYST_NEG = -HYST_POS;
  localparam logic signed [DIFF_W-1:0] TOL_S    = DIFF_W'(TOL);
  localparam logic [MC_W-1:0]          LOCK_M   = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       arm_q, arm_d;
  logic [DATA_W-1:0]          cnt_q, cnt_d;
  logic [MC_W-1:0]            match_q, match_d;
  logic [DATA_W-1:0]          ref_q, ref_d;
  logic                       ref_vld_q, ref_vld_d;
  logic [DATA_W-1:0]          period_p1, period_d;
  logic                       vld_p1, vld_d;
  logic                       tmo_p1, tmo_d;
  logic                       locked_p1, locked_d;
  logic signed [DIFF_W-1:0]   sample_x;
  logic                       crossing;
  logic                       same;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] c);
    if (c >= MAX_PERIOD) return MAX_PERIOD;
    return c + 16'd1;
  endfunction

  function automatic logic [MC_W-1:0] sat_match(input logic [MC_W-1:0] m);
    if (m >= LOCK_M) return LOCK_M;
    return m + 1'b1;
  endfunction

  // |a - b| <= TOL, computed on 17-bit signed values so that any pair of
  // 16-bit periods gives an exact difference.
  function automatic logic period_match(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    logic signed [DIFF_W-1:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff[DIFF_W-1]) diff = -diff;
    return (diff <= TOL_S);
  endfunction

  assign sample_x = {sample[DATA_W-1], sample};

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    period_d  = period_p1;
    vld_d     = 1'b0;
    tmo_d     = 1'b0;
    locked_d  = locked_p1;
    crossing  = 1'b0;
    same      = 1'b0;

    if (sample_valid) begin
      crossing = arm_q && (sample_x >= HYST_POS);
      // cnt counts the crossing sample itself as 1, so at the next crossing
      // it holds exactly the number of valid samples in between.
      cnt_d    = crossing ? 16'd1 : sat_inc(cnt_q);

      if (crossing)                   arm_d = 1'b0;
      else if (sample_x <= HYST_NEG)  arm_d = 1'b1;

      if (crossing) begin
        if (state_q == IDLE) begin
          // Only opens a measurement window; no period yet.
          state_d   = MEASURE;
          ref_vld_d = 1'b0;
          match_d   = '0;
        end else begin
          period_d  = cnt_q;
          vld_d     = 1'b1;
          ref_d     = cnt_q;
          ref_vld_d = 1'b1;
          same      = ref_vld_q && period_match(cnt_q, ref_q);
          match_d   = same ? sat_match(match_q) : '0;
          if (state_q == MEASURE && match_d == LOCK_M) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else if (state_q == LOCKED && !same) begin
            state_d  = MEASURE;
            locked_d = 1'b0;
          end
        end
      end else if (state_q != IDLE && cnt_q == MAX_PERIOD) begin
        // A crossing on this same sample would have taken the branch above.
        tmo_d     = 1'b1;
        state_d   = IDLE;
        locked_d  = 1'b0;
        arm_d     = 1'b0;
        match_d   = '0;
        ref_vld_d = 1'b0;
      end
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      arm_q     <= 1'b0;
      cnt_q     <= '0;
      match_q   <= '0;
      ref_vld_q <= 1'b0;
      period_p1 <= '0;
      vld_p1    <= 1'b0;
      tmo_p1    <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      ref_vld_q <= ref_vld_d;
      period_p1 <= period_d;
      vld_p1    <= vld_d;
      tmo_p1    <= tmo_d;
      locked_p1 <= locked_d;
    end
  end

  // Reference period is only ever read while ref_vld_q is set.
  always_ff @(posedge clk) begin
    ref_q <= ref_d;
  end

  assign period       = period_p1;
  assign period_valid = vld_p1;
  assign locked       = locked_p1;
  assign timeout      = tmo_p1;

endmodule
